// File: rtl/dm_abstract_cmd_ctrl.sv
// Abstract command sequencer: validates Command writes, owns abstractcs busy/cmderr,
// and runs the go/ack/done handshake with the halted hart.
module dm_abstract_cmd_ctrl #(
    parameter logic        HasFpu        = 1'b1,
    parameter logic [2:0]  MaxAarSize    = 3'd3,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dmactive_i,
    input  logic        cmd_valid_i,
    input  logic [31:0] cmd_i,
    input  logic        autoexec_i,
    input  logic        busy_access_i,
    input  logic        cmderr_clr_valid_i,
    input  logic [2:0]  cmderr_clr_i,
    input  logic        hart_halted_i,
    output logic        go_o,
    input  logic        go_ack_i,
    input  logic        done_i,
    input  logic        exception_i,
    output logic        busy_o,
    output logic [2:0]  cmderr_o,
    output logic [31:0] cmd_o,
    output logic        cmd_start_o
);
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    typedef enum logic [2:0] {
        CmdErrNone         = 3'd0,
        CmdErrBusy         = 3'd1,
        CmdErrNotSupported = 3'd2,
        CmdErrException    = 3'd3,
        CmdErrHaltResume   = 3'd4,
        CmdErrBus          = 3'd5,
        CmdErrOther        = 3'd7
    } cmderr_e;

    typedef enum logic [1:0] {StIdle, StGo, StWait} state_e;

    typedef struct packed {
        logic [7:0]  cmdtype;
        logic        zero;
        logic [2:0]  aarsize;
        logic        aarpostincrement;
        logic        postexec;
        logic        transfer;
        logic        write;
        logic [15:0] regno;
    } ac_ar_cmd_t;

    state_e          state_q;
    cmderr_e         cmderr_q, cmderr_d;
    logic            busy_q, go_q, start_q;
    ac_ar_cmd_t      cmd_q;
    logic [CntW-1:0] cnt_q;

    ac_ar_cmd_t chk_cmd;
    cmderr_e    chk_err, new_err;
    logic       issue, chk_go, regno_ok, size_ok, timeout;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        chk_cmd  = cmd_valid_i ? ac_ar_cmd_t'(cmd_i) : cmd_q;
        issue    = (state_q == StIdle) && (cmderr_q == CmdErrNone) && (cmd_valid_i || autoexec_i);
        regno_ok = (chk_cmd.regno <= 16'h0FFF)
                || (chk_cmd.regno >= 16'h1000 && chk_cmd.regno <= 16'h101F)
                || (HasFpu && chk_cmd.regno >= 16'h1020 && chk_cmd.regno <= 16'h103F);
        size_ok  = (chk_cmd.aarsize <= MaxAarSize) && (chk_cmd.aarsize >= 3'd2);
        chk_go   = chk_cmd.transfer || chk_cmd.postexec;

        chk_err = CmdErrNone;
        if (chk_cmd.cmdtype != 8'd0)                      chk_err = CmdErrNotSupported;
        else if (chk_cmd.transfer && !(size_ok && regno_ok)) chk_err = CmdErrNotSupported;
        else if (chk_cmd.aarpostincrement)                chk_err = CmdErrNotSupported;
        else if (!hart_halted_i)                          chk_err = CmdErrHaltResume;

        timeout = (state_q == StGo) && !go_ack_i && (cnt_q == CntW'(TimeoutCycles - 1));

        new_err = CmdErrNone;
        if (issue)                                        new_err = chk_err;
        else if (state_q == StWait && exception_i)        new_err = CmdErrException;
        else if (timeout)                                 new_err = CmdErrOther;
        else if (busy_q && (busy_access_i || cmd_valid_i || autoexec_i)) new_err = CmdErrBusy;

        // First error sticks; a fresh error beats a same-cycle clear.
        cmderr_d = cmderr_q;
        if (new_err != CmdErrNone && cmderr_q == CmdErrNone) cmderr_d = new_err;
        else if (cmderr_clr_valid_i && !busy_q)              cmderr_d = cmderr_e'(cmderr_q & ~cmderr_clr_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_ni) begin
            state_q  <= StIdle;
            cmderr_q <= CmdErrNone;
            busy_q   <= 1'b0;
            go_q     <= 1'b0;
            start_q  <= 1'b0;
            cmd_q    <= '0;
            cnt_q    <= '0;
        end else if (!dmactive_i) begin
            state_q  <= StIdle;
            cmderr_q <= CmdErrNone;
            busy_q   <= 1'b0;
            go_q     <= 1'b0;
            start_q  <= 1'b0;
            cmd_q    <= '0;
            cnt_q    <= '0;
        end else begin
            cmderr_q <= cmderr_d;
            start_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (issue) begin
                        cmd_q <= chk_cmd;
                        if (chk_err == CmdErrNone) begin
                            start_q <= 1'b1;
                            if (chk_go) begin
                                state_q <= StGo;
                                go_q    <= 1'b1;
                                busy_q  <= 1'b1;
                                cnt_q   <= '0;
                            end
                        end
                    end
                end
                StGo: begin
                    if (go_ack_i) begin
                        state_q <= StWait;
                        go_q    <= 1'b0;
                        cnt_q   <= '0;
                    end else if (timeout) begin
                        state_q <= StIdle;
                        go_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWait: begin
                    if (exception_i || done_i) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    go_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign go_o        = go_q;
    assign busy_o      = busy_q;
    assign cmderr_o    = cmderr_q;
    assign cmd_o       = cmd_q;
    assign cmd_start_o = start_q;

endmodule

// File: doc/dm_abstract_cmd_ctrl.md
Name: dm_abstract_cmd_ctrl

Overview:
Sequencer for abstract commands in the debug module.
- Validates Command writes arriving over DMI, owns the abstractcs busy/cmderr state, and hands the command to the halted hart through the go/ack handshake.
- Sits between the DMI register file (dm_csrs) and the debug memory/program generator (dm_mem), which consumes the latched command.

Parameters:
HasFpu, 1'b1, FPR regno range 0x1020-0x103F is supported
MaxAarSize, 3'd3, largest supported aarsize (3 = 64-bit)
TimeoutCycles, 1024, cycles allowed for go_ack_i before abort; counter width $clog2(TimeoutCycles+1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
dmactive_i  in  1  dmcontrol.dmactive; low = synchronous clear
cmd_valid_i  in  1  DMI write to Command (0x17), single-cycle pulse
cmd_i  in  32  write data: cmdtype[31:24], control[23:0] as ac_ar_cmd layout
autoexec_i  in  1  autoexec trigger from a data/progbuf access, single-cycle pulse
busy_access_i  in  1  DMI write to command/abstractcs/abstractauto/data/progbuf this cycle
cmderr_clr_valid_i  in  1  DMI write to abstractcs
cmderr_clr_i  in  3  abstractcs write data [10:8], W1C
hart_halted_i  in  1  selected hart is halted
go_o  out  1  request hart to execute the abstract command
go_ack_i  in  1  hart has left the park loop (going)
done_i  in  1  hart back in park loop after execution
exception_i  in  1  hart trapped during execution
busy_o  out  1  abstractcs.busy
cmderr_o  out  3  abstractcs.cmderr (cmderr_e encoding)
cmd_o  out  32  latched command for program generation
cmd_start_o  out  1  pulse: cmd_o updated and accepted

Behaviour:
- Reset/dmactive low: state IDLE; busy_o=0, go_o=0, cmderr_o=CmdErrNone, cmd_o=0, cmd_start_o=0, timeout counter=0. Reset mid-operation aborts with no error recorded.
- States: IDLE, GO, WAIT. busy_o=1 in GO and WAIT.
- IDLE, cmd_valid_i=1, cmderr_o==None: cmd_o<=cmd_i at the next edge, then check:
  - cmdtype!=AccessRegister -> cmderr NotSupported.
  - aarsize>MaxAarSize or aarsize<2 with transfer=1 -> NotSupported.
  - regno outside CSR 0x0000-0x0FFF / GPR 0x1000-0x101F / FPR (if HasFpu) with transfer=1 -> NotSupported.
  - aarpostincrement=1 -> NotSupported.
  - hart_halted_i=0 -> HaltResume.
  - transfer=0 and postexec=0 -> accepted; cmd_start_o pulses; stays IDLE; no go.
  - Otherwise -> GO: cmd_start_o=1 and go_o=1 in cycle N+1.
- IDLE, cmd_valid_i with cmderr_o!=None: command ignored; cmd_o unchanged.
- autoexec_i in IDLE: re-issues the held cmd_o through the same checks. It is ignored if cmderr_o!=None.
- GO: go_o held high until go_ack_i. go_ack_i -> WAIT; go_o drops the same edge. The counter increments each GO cycle; reaching TimeoutCycles -> cmderr Other, IDLE.
- WAIT: exception_i -> cmderr Exception, IDLE. done_i -> IDLE. Both in the same cycle: exception wins.
- Busy violations: busy_access_i, cmd_valid_i or autoexec_i while busy_o=1 -> cmderr Busy. The running command continues.
- cmderr write rule: only written when the current value is None (first error sticks).
- Clear: cmderr_clr_valid_i with busy_o=0 -> cmderr_o &= ~cmderr_clr_i. It is ignored while busy.
- Clear and a new error in the same cycle: the new error wins.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Halted hart; cmd_i=0x0032_1008 (AccessRegister, aarsize 3, transfer, regno 0x1008) -> busy_o=1, go_o=1 at N+1. go_ack_i at N+3, then done_i at N+6 -> busy_o=0 at N+7; cmderr_o=0; cmd_o=0x0032_1008.
2. cmd_i=0x0100_0000 (QuickAccess) -> cmderr_o=2, busy_o stays 0. Then clear with cmderr_clr_i=3'b111 -> cmderr_o=0.
3. hart_halted_i=0, valid register command -> cmderr_o=4, no go_o. A following valid command is ignored until cleared.
4. During WAIT: busy_access_i pulse -> cmderr_o=1, busy stays 1. Then exception_i and done_i in the same cycle -> busy_o=0, cmderr_o stays 1 (sticky).
5. go_ack_i never asserted -> cmderr_o=7 and busy_o=0 after exactly TimeoutCycles GO cycles. rst_ni low in WAIT -> all outputs 0 asynchronously.
6. After test 1, autoexec_i pulse -> second go_o with an identical cmd_o and a cmd_start_o pulse.
